frame_store: RTL

Double-buffered serial-to-parallel frame capture register. Bits arriving on `txda` are written one at a time, at the bit index given on `ramadrs`. A frame is complete once every bit position has been written, and it is then presented on `buffer` under a ready/ack handshake. This block is the parametrised successor of the single-bank storage register on the receive datapath, and adds per-bit completion tracking, ping-pong banking and overflow/address-error reporting.

---
 rtl/store_pkg.sv | 37 +++
 rtl/store_bank.sv | 61 ++++++
 rtl/frame_store.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the frame_store block: FSM encoding, bank index
// type, debug view and the mask-completion helper.
package store_pkg;

    // Frame presentation states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    // Selects one of the two ping-pong banks.
    typedef logic bank_idx_t;

    // Widest frame the completion helper can evaluate.
    localparam int MAX_BUFFER_SIZE = 256;

    // Internal view exported for observation: FSM state, fill bank and bank fullness.
    typedef struct packed {
        state_t    state;
        bank_idx_t fill_sel;
        logic [1:0] full;
    } dbg_t;

    // True when the mask would be all-ones once bit idx is set.
    // Callers pad unused upper bits of the mask with ones.
    function automatic logic mask_full_after_write(
        input logic [MAX_BUFFER_SIZE-1:0] mask,
        input int unsigned                idx
    );
        logic [MAX_BUFFER_SIZE-1:0] m;
        m      = mask;
        m[idx] = 1'b1;
        return &m;
    endfunction

endpackage

// File: rtl/store_bank.sv
// One frame bank: data register, per-bit valid mask and full flag.
// Exposes the post-edge data so the top can register it straight into
// its output without an extra cycle of lag.
module store_bank
    import store_pkg::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int ADRS_WIDTH  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADRS_WIDTH-1:0]  wr_idx,
    input  logic                   wr_bit,
    input  logic                   clear,
    output logic [BUFFER_SIZE-1:0] data_next,
    output logic                   full,
    output logic                   complete
);

    logic [BUFFER_SIZE-1:0]     data;
    logic [BUFFER_SIZE-1:0]     valid;
    logic [BUFFER_SIZE-1:0]     valid_next;
    logic                       full_next;
    logic [MAX_BUFFER_SIZE-1:0] mask_ext;

    // Next-state of the bank: clear wins over a write; a rewrite of a valid bit only updates data.
    always_comb begin
        mask_ext                    = '1;
        mask_ext[BUFFER_SIZE-1:0]   = valid;
        complete                    = wr_en && mask_full_after_write(mask_ext, 32'(wr_idx));
        data_next                   = data;
        valid_next                  = valid;
        full_next                   = full;
        if (clear) begin
            data_next  = '0;
            valid_next = '0;
            full_next  = 1'b0;
        end else if (wr_en) begin
            data_next[wr_idx]  = wr_bit;
            valid_next[wr_idx] = 1'b1;
            if (complete) begin
                full_next = 1'b1;
            end
        end
    end

    // Bank storage with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data  <= '0;
            valid <= '0;
            full  <= 1'b0;
        end else begin
            data  <= data_next;
            valid <= valid_next;
            full  <= full_next;
        end
    end

endmodule

// File: rtl/frame_store.sv
// Double-buffered serial-to-parallel frame capture register.
// Bits are written into the fill bank; a completed bank becomes the read
// bank and is presented on buffer under a frame_ready/frame_ack handshake.
// Handshake: a frame transfers at a rising edge where frame_ready=1 and
// frame_ack=1; frame_ack is ignored while frame_ready=0, and buffer is held
// stable from the rise of frame_ready until that edge.
// Optional feature macro: FRAME_STORE_PARITY_EN adds frame_parity.
module frame_store
    import store_pkg::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int ADRS_WIDTH  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   oeenable,
    input  logic [ADRS_WIDTH-1:0]  ramadrs,
    input  logic                   txda,
    input  logic                   frame_ack,
    output logic                   frame_ready,
    output logic [BUFFER_SIZE-1:0] buffer,
    output logic                   overflow,
    output logic                   addr_err,
`ifdef FRAME_STORE_PARITY_EN
    output logic                   frame_parity,
`endif
    output dbg_t                   dbg
);

    localparam logic [ADRS_WIDTH:0] SIZE_L = (ADRS_WIDTH+1)'(BUFFER_SIZE);

    state_t    state;
    state_t    state_next;
    bank_idx_t fill_sel;
    bank_idx_t fill_sel_next;
    bank_idx_t read_sel;

    logic wr_req;
    logic in_range;
    logic fill_wr;
    logic ack;
    logic complete;

    logic [1:0]             bank_wr;
    logic [1:0]             bank_clr;
    logic [1:0]             bank_full;
    logic [1:0]             bank_complete;
    logic [BUFFER_SIZE-1:0] bank_data_next [2];
    logic [BUFFER_SIZE-1:0] buffer_d;
    logic                   ready_d;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        store_bank #(
            .BUFFER_SIZE (BUFFER_SIZE),
            .ADRS_WIDTH  (ADRS_WIDTH)
        ) u_bank (
            .clock     (clock),
            .reset     (reset),
            .wr_en     (bank_wr[b]),
            .wr_idx    (ramadrs),
            .wr_bit    (txda),
            .clear     (bank_clr[b]),
            .data_next (bank_data_next[b]),
            .full      (bank_full[b]),
            .complete  (bank_complete[b])
        );
    end

    // Write steering: in-range writes go to the fill bank unless both banks are full.
    always_comb begin
        read_sel          = ~fill_sel;
        wr_req            = ~oeenable;
        in_range          = ({1'b0, ramadrs} < SIZE_L);
        fill_wr           = wr_req && in_range && (state != STALL);
        ack               = frame_ack && frame_ready;
        bank_wr           = '0;
        bank_wr[fill_sel] = fill_wr;
        complete          = bank_complete[fill_sel];
    end

    // FSM next state, bank swap and read-bank clear.
    always_comb begin
        state_next    = state;
        fill_sel_next = fill_sel;
        bank_clr      = '0;
        case (state)
            IDLE: begin
                if (complete) begin
                    fill_sel_next = ~fill_sel;
                    state_next    = PEND;
                end
            end
            PEND: begin
                if (ack && complete) begin
                    bank_clr[read_sel] = 1'b1;
                    fill_sel_next      = ~fill_sel;
                end else if (ack) begin
                    bank_clr[read_sel] = 1'b1;
                    state_next         = IDLE;
                end else if (complete) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (ack) begin
                    bank_clr[read_sel] = 1'b1;
                    fill_sel_next      = ~fill_sel;
                    state_next         = PEND;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Outputs follow the read bank as it will be after this edge.
        buffer_d = bank_data_next[~fill_sel_next];
        ready_d  = (state_next != IDLE);
    end

    // State, bank select, registered outputs and sticky flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            fill_sel     <= 1'b0;
            buffer       <= '0;
            frame_ready  <= 1'b0;
            overflow     <= 1'b0;
            addr_err     <= 1'b0;
`ifdef FRAME_STORE_PARITY_EN
            frame_parity <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            fill_sel     <= fill_sel_next;
            buffer       <= buffer_d;
            frame_ready  <= ready_d;
            overflow     <= overflow | (wr_req && in_range && (state == STALL));
            addr_err     <= addr_err | (wr_req && !in_range);
`ifdef FRAME_STORE_PARITY_EN
            frame_parity <= ^buffer_d;
`endif
        end
    end

    // Observation view of the internal control state.
    always_comb begin
        dbg.state    = state;
        dbg.fill_sel = fill_sel;
        dbg.full     = bank_full;
    end

endmodule
